cdb_broadcaster: RTL and testbench
==================================

Name: cdb_broadcaster

Overview:
- Transmitting end of the CDB completion protocol that the ROB consumes.
- Collects completed results (ROB tag plus value) from the functional units.
- Buffers them in small per-FU FIFOs and arbitrates round-robin.
- Drives exactly one registered broadcast per cycle to the ROB, RS and map table; squash flushes all in-flight results.

Parameters:
- NUM_FU, 4, number of functional-unit completion ports
- FIFO_DEPTH, 2, entries per FU FIFO (power of two, ≥2)
- TAG_W, 4, ROB tag width; tag 0 is reserved as "no broadcast"
- XLEN, 32, result value width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- fu_valid  in  NUM_FU  per-FU completion valid
- fu_rob_tag  in  NUM_FU*TAG_W  per-FU ROB tag; slice i = [i*TAG_W +: TAG_W]
- fu_value  in  NUM_FU*XLEN  per-FU result value; slice i = [i*XLEN +: XLEN]
- fu_ready  out  NUM_FU  per-FU accept; a transfer occurs on fu_valid&&fu_ready at a rising edge
- squash_valid  in  1  mispredict flush
- cdb_valid  out  1  broadcast valid (registered)
- cdb_rob_tag  out  TAG_W  broadcast tag (registered); 0 when cdb_valid=0
- cdb_v  out  XLEN  broadcast value (registered); 0 when cdb_valid=0
- fifo_occupancy  out  NUM_FU*2  per-FU entry count, saturating display of count (debug/perf)

Behaviour:
- Reset (reset=0, async): all FIFOs empty, pointers 0, rr_ptr=0, cdb_valid=0, cdb_rob_tag=0, cdb_v=0. While reset=0, fu_ready forced 0.
- fu_ready[i] = (count[i] < FIFO_DEPTH).
  - Depends only on registered count; no same-cycle pop-through.
  - A full FIFO with a pop this cycle still shows ready=0.
- Enqueue: fu_valid[i]&&fu_ready[i] at an edge writes {tag,value} at wr_ptr[i]; wr_ptr increments mod FIFO_DEPTH.
- An input with tag 0 is accepted (handshake completes) but discarded, never enqueued.
- Arbitration (combinational, cycle after enqueue):
  - Scan FIFOs i = rr_ptr, rr_ptr+1, … mod NUM_FU; grant the first non-empty one.
  - On grant g: pop head of g, rr_ptr <= (g+1) mod NUM_FU.
  - No grant: rr_ptr holds.
- Output register at each edge:
  - Grant: cdb_valid<=1, cdb_rob_tag<=head tag, cdb_v<=head value.
  - No grant: cdb_valid<=0, tag<=0, value<=0.
  - Each broadcast lasts exactly one cycle.
- Latency: handshake at edge E → earliest cdb_valid high after edge E+1. Throughput is 1 broadcast/cycle total.
- Simultaneous push and pop on the same FIFO: both occur, count unchanged, ordering preserved (FIFO order per FU).
- Squash (squash_valid=1 at an edge, reset deasserted):
  - All FIFOs cleared (counts, pointers to 0).
  - Same-cycle inputs dropped, even if ready=1.
  - cdb_valid/tag/value <= 0. rr_ptr unchanged.
  - Pending output is also killed; no broadcast occurs in the cycle after squash.
- Reset asserted mid-operation overrides everything immediately (async), including a pending squash.
- Pointer/count arithmetic: pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2(FIFO_DEPTH)+1 bits.

Test Plan:
- Reset then idle → cdb_valid=0, cdb_rob_tag=0, fu_ready=4'b1111 after reset=1, fifo_occupancy all 0.
- Single completion: FU1 tag=5 value=0xDEAD_BEEF at edge E → cdb_valid=1, tag=5, cdb_v=0xDEADBEEF in the cycle after E+1 only; next cycle tag=0.
- Contention: all 4 FUs push at the same edge (tags 1,2,3,4), rr_ptr=0 → broadcasts tags 1,2,3,4 on 4 consecutive cycles; rr_ptr ends at 0.
- Backpressure: FU2 pushes tags 6,7,8 on consecutive edges while FU0 floods → FU2 fu_ready=0 after 2 entries. Tag 8 is held and accepted later. Broadcast order for FU2 is 6,7,8; FU0 and FU2 interleave round-robin.
- Squash: FIFOs hold 3 entries and cdb is about to broadcast tag 9; assert squash_valid one cycle → no broadcast of 9 or any queued tag; occupancy 0. A new tag 10 pushed the next cycle broadcasts normally.
- Tag-0 input and async reset: FU3 pushes tag 0 → handshake completes, nothing broadcast. Pull reset low mid-cycle with entries queued → outputs 0 immediately, fu_ready=0 until release.

Source files
------------

// File: rtl/cdb_broadcaster.sv
// ---------------------------------------------------------------------------
// cdb_broadcaster
//
// Transmitting end of the common data bus. Each functional unit hands over
// completed results ({ROB tag, value}) through a valid/ready handshake into
// its own small FIFO. A round-robin arbiter picks one non-empty FIFO per
// cycle and its head is driven onto a registered broadcast bus for the ROB,
// reservation stations and map table. A squash empties every FIFO and kills
// the broadcast that would have gone out next.
//
// Ports
//   clock           system clock, rising edge
//   reset           asynchronous active-low reset
//   fu_valid        per-FU completion valid                    [NUM_FU]
//   fu_rob_tag      per-FU ROB tag, slice i = [i*TAG_W +: TAG_W]
//   fu_value        per-FU result, slice i = [i*XLEN +: XLEN]
//   fu_ready        per-FU accept (FIFO not full, 0 during reset)
//   squash_valid    mispredict flush
//   cdb_valid       registered broadcast valid
//   cdb_rob_tag     registered broadcast tag (0 when idle)
//   cdb_v           registered broadcast value (0 when idle)
//   fifo_occupancy  per-FU entry count, 2 bits each, saturating at 3
// ---------------------------------------------------------------------------
module cdb_broadcaster #(
  parameter int NUM_FU     = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int TAG_W      = 4,
  parameter int XLEN       = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_FU-1:0]       fu_valid,
  input  logic [NUM_FU*TAG_W-1:0] fu_rob_tag,
  input  logic [NUM_FU*XLEN-1:0]  fu_value,
  output logic [NUM_FU-1:0]       fu_ready,
  input  logic                    squash_valid,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_rob_tag,
  output logic [XLEN-1:0]         cdb_v,
  output logic [NUM_FU*2-1:0]     fifo_occupancy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int RW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  value;
  } entry_t;

  entry_t        mem    [NUM_FU][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr [NUM_FU];
  logic [PW-1:0] rd_ptr [NUM_FU];
  logic [CW-1:0] count  [NUM_FU];
  logic [RW-1:0] rr_ptr;

  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  logic              grant_valid;
  logic [RW-1:0]     grant_idx;
  logic [RW-1:0]     rr_next;
  entry_t            head;

  // Ready looks only at the registered count, so a full FIFO being popped
  // this cycle still refuses input.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = reset && (count[i] < CW'(FIFO_DEPTH));
    end
  end

  // Tag 0 means "no broadcast": such inputs complete the handshake but are
  // dropped. Squash drops every same-cycle input.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      push[i] = fu_valid[i] && fu_ready[i] && !squash_valid &&
                (fu_rob_tag[i*TAG_W +: TAG_W] != '0);
    end
  end

  // Round-robin scan starting at rr_ptr; first non-empty FIFO wins.
  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_idx   = rr_ptr;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_FU;
      if (!grant_valid && (count[idx] != '0)) begin
        grant_valid = 1'b1;
        grant_idx   = RW'(idx);
      end
    end
  end

  assign rr_next = RW'((int'(grant_idx) + 1) % NUM_FU);
  assign head    = mem[grant_idx][rd_ptr[grant_idx]];

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      pop[i] = grant_valid && (grant_idx == RW'(i)) && !squash_valid;
    end
  end

  // FIFO pointers and counts. Depth is a power of two, so the pointers wrap
  // on their own.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else if (squash_valid) begin
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
        if (push[i] && !pop[i])      count[i] <= count[i] + CW'(1);
        else if (pop[i] && !push[i]) count[i] <= count[i] - CW'(1);
      end
    end
  end

  // NOTE: FIFO storage has no reset; the counts alone decide which entries
  // are live, so resetting the array would only cost area.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= {fu_rob_tag[i*TAG_W +: TAG_W],
                              fu_value[i*XLEN +: XLEN]};
      end
    end
  end

  // Arbitration pointer advances past the winner; squash leaves it alone.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (!squash_valid && grant_valid) begin
      rr_ptr <= rr_next;
    end
  end

  // Broadcast register: one cycle per granted entry, zeros otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cdb_valid   <= 1'b0;
      cdb_rob_tag <= '0;
      cdb_v       <= '0;
    end else if (!squash_valid && grant_valid) begin
      cdb_valid   <= 1'b1;
      cdb_rob_tag <= head.tag;
      cdb_v       <= head.value;
    end else begin
      cdb_valid   <= 1'b0;
      cdb_rob_tag <= '0;
      cdb_v       <= '0;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      fifo_occupancy[i*2 +: 2] = (count[i] > CW'(3)) ? 2'd3 : 2'(count[i]);
    end
  end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// ---------------------------------------------------------------------------
// tb_cdb_broadcaster
//
// Self-checking bench for cdb_broadcaster. A queue-per-FU reference model is
// advanced once per clock edge from the same inputs the DUT sees; each test
// task compares DUT outputs against that model or against fixed values.
// ---------------------------------------------------------------------------
module tb_cdb_broadcaster;

  localparam int NUM_FU     = 4;
  localparam int FIFO_DEPTH = 2;
  localparam int TAG_W      = 4;
  localparam int XLEN       = 32;

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic [NUM_FU-1:0]       fu_valid;
  logic [NUM_FU*TAG_W-1:0] fu_rob_tag;
  logic [NUM_FU*XLEN-1:0]  fu_value;
  logic [NUM_FU-1:0]       fu_ready;
  logic                    squash_valid;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_rob_tag;
  logic [XLEN-1:0]         cdb_v;
  logic [NUM_FU*2-1:0]     fifo_occupancy;

  cdb_broadcaster #(
    .NUM_FU(NUM_FU), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)
  ) dut (
    .clock(clock),
    .reset(reset),
    .fu_valid(fu_valid),
    .fu_rob_tag(fu_rob_tag),
    .fu_value(fu_value),
    .fu_ready(fu_ready),
    .squash_valid(squash_valid),
    .cdb_valid(cdb_valid),
    .cdb_rob_tag(cdb_rob_tag),
    .cdb_v(cdb_v),
    .fifo_occupancy(fifo_occupancy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  value;
  } ent_t;

  ent_t             q [NUM_FU][$];
  int               rr;
  logic             exp_valid;
  logic [TAG_W-1:0] exp_tag;
  logic [XLEN-1:0]  exp_v;

  task automatic model_reset();
    for (int i = 0; i < NUM_FU; i++) q[i].delete();
    rr        = 0;
    exp_valid = 1'b0;
    exp_tag   = '0;
    exp_v     = '0;
  endtask

  function automatic logic [NUM_FU-1:0] exp_ready();
    logic [NUM_FU-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_FU; i++) r[i] = (q[i].size() < FIFO_DEPTH);
    return r;
  endfunction

  function automatic logic [NUM_FU*2-1:0] exp_occ();
    logic [NUM_FU*2-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_FU; i++)
      r[i*2 +: 2] = (q[i].size() > 3) ? 2'd3 : 2'(q[i].size());
    return r;
  endfunction

  // Apply one clock edge to the model, then advance the real clock and land
  // 1 time unit after the edge, where outputs are sampled.
  task automatic cycle();
    logic [NUM_FU-1:0] rdy;
    int                g;
    ent_t              e;
    rdy = exp_ready();
    if (squash_valid) begin
      for (int i = 0; i < NUM_FU; i++) q[i].delete();
      exp_valid = 1'b0;
      exp_tag   = '0;
      exp_v     = '0;
    end else begin
      g = -1;
      for (int k = 0; k < NUM_FU; k++) begin
        if (g < 0 && q[(rr + k) % NUM_FU].size() > 0) g = (rr + k) % NUM_FU;
      end
      if (g >= 0) begin
        e         = q[g].pop_front();
        exp_valid = 1'b1;
        exp_tag   = e.tag;
        exp_v     = e.value;
        rr        = (g + 1) % NUM_FU;
      end else begin
        exp_valid = 1'b0;
        exp_tag   = '0;
        exp_v     = '0;
      end
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_valid[i] && rdy[i] && fu_rob_tag[i*TAG_W +: TAG_W] != '0)
          q[i].push_back({fu_rob_tag[i*TAG_W +: TAG_W], fu_value[i*XLEN +: XLEN]});
      end
    end
    @(posedge clock);
    #1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    fu_valid     = '0;
    fu_rob_tag   = '0;
    fu_value     = '0;
    squash_valid = 1'b0;
  endtask

  task automatic drive(input int i, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v);
    fu_valid[i]                 = 1'b1;
    fu_rob_tag[i*TAG_W +: TAG_W] = t;
    fu_value[i*XLEN +: XLEN]     = v;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    model_reset();
    #2;
    checks++;
    if (fu_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready_low: got %b want 0000", fu_ready);
    end
    checks++;
    if ({cdb_valid, cdb_rob_tag, cdb_v, fifo_occupancy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b tag=%0d v=%h occ=%b want all 0",
               cdb_valid, cdb_rob_tag, cdb_v, fifo_occupancy);
    end
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    checks++;
    if (fu_ready !== 4'b1111 || fifo_occupancy !== '0 || cdb_valid !== 1'b0 ||
        cdb_rob_tag !== '0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b occ=%b valid=%b tag=%0d want 1111/0/0/0",
               fu_ready, fifo_occupancy, cdb_valid, cdb_rob_tag);
    end
  endtask

  task automatic test_single();
    idle();
    drive(1, 4'd5, 32'hDEAD_BEEF);
    cycle();
    idle();
    checks++;
    if (cdb_valid !== 1'b0 || fifo_occupancy !== 8'b0000_0100) begin
      errors++;
      $display("FAIL single_enqueued: got valid=%b occ=%b want 0 / 00000100",
               cdb_valid, fifo_occupancy);
    end
    cycle();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_rob_tag !== 4'd5 || cdb_v !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_bcast: got valid=%b tag=%0d v=%h want 1/5/deadbeef",
               cdb_valid, cdb_rob_tag, cdb_v);
    end
    cycle();
    checks++;
    if (cdb_valid !== 1'b0 || cdb_rob_tag !== 4'd0 || cdb_v !== '0) begin
      errors++;
      $display("FAIL single_oneshot: got valid=%b tag=%0d v=%h want 0/0/0",
               cdb_valid, cdb_rob_tag, cdb_v);
    end
  endtask

  task automatic test_contention();
    logic [TAG_W-1:0] want;
    // Bring the arbitration pointer to 0 by granting FU3 once.
    idle();
    drive(3, 4'd15, 32'h0000_0F0F);
    cycle();
    idle();
    cycle();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_rob_tag !== 4'd15) begin
      errors++;
      $display("FAIL contention_prep: got valid=%b tag=%0d want 1/15", cdb_valid, cdb_rob_tag);
    end
    for (int i = 0; i < NUM_FU; i++) drive(i, TAG_W'(i + 1), 32'h1000_0000 + 32'(i));
    cycle();
    idle();
    for (int n = 0; n < NUM_FU; n++) begin
      cycle();
      want = TAG_W'(n + 1);
      checks++;
      if (cdb_valid !== 1'b1 || cdb_rob_tag !== want ||
          cdb_v !== 32'h1000_0000 + 32'(n)) begin
        errors++;
        $display("FAIL contention_order[%0d]: got valid=%b tag=%0d v=%h want 1/%0d",
                 n, cdb_valid, cdb_rob_tag, cdb_v, want);
      end
    end
    cycle();
    checks++;
    if (cdb_valid !== 1'b0 || fifo_occupancy !== '0) begin
      errors++;
      $display("FAIL contention_drained: got valid=%b occ=%b want 0/0", cdb_valid, fifo_occupancy);
    end
  endtask

  task automatic test_backpressure();
    logic [TAG_W-1:0] fu2_tags [3];
    logic [TAG_W-1:0] seen [$];
    int               p;
    bit               saw_stall;
    fu2_tags[0] = 4'd6;
    fu2_tags[1] = 4'd7;
    fu2_tags[2] = 4'd8;
    p         = 0;
    saw_stall = 1'b0;
    for (int c = 0; c < 16; c++) begin
      idle();
      drive(0, TAG_W'(1 + $urandom_range(0, 4)), $urandom);
      if (p < 3) drive(2, fu2_tags[p], 32'hB000_0000 + 32'(p));
      checks++;
      if (fu_ready !== exp_ready()) begin
        errors++;
        $display("FAIL bp_ready c%0d: got %b want %b", c, fu_ready, exp_ready());
      end
      if (p < 3 && !exp_ready()[2]) saw_stall = 1'b1;
      if (p < 3 && exp_ready()[2]) p++;
      cycle();
      checks++;
      if ({cdb_valid, cdb_rob_tag, cdb_v, fifo_occupancy} !==
          {exp_valid, exp_tag, exp_v, exp_occ()}) begin
        errors++;
        $display("FAIL bp_out c%0d: got v=%b t=%0d d=%h o=%b want v=%b t=%0d d=%h o=%b",
                 c, cdb_valid, cdb_rob_tag, cdb_v, fifo_occupancy,
                 exp_valid, exp_tag, exp_v, exp_occ());
      end
      if (cdb_valid && cdb_rob_tag >= 4'd6 && cdb_rob_tag <= 4'd8) seen.push_back(cdb_rob_tag);
    end
    idle();
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (cdb_valid && cdb_rob_tag >= 4'd6 && cdb_rob_tag <= 4'd8) seen.push_back(cdb_rob_tag);
    end
    checks++;
    if (!saw_stall) begin
      errors++;
      $display("FAIL bp_stall: FU2 never back-pressured, want a stall after 2 entries");
    end
    checks++;
    if (seen.size() != 3 || seen[0] !== 4'd6 || seen[1] !== 4'd7 || seen[2] !== 4'd8) begin
      errors++;
      $display("FAIL bp_fu2_order: got %0d tags (%p) want 6,7,8", seen.size(), seen);
    end
  endtask

  task automatic test_squash();
    int r;
    idle();
    repeat (4) cycle();
    r = rr;
    drive(r, 4'd9, 32'h0000_0009);
    drive((r + 1) % NUM_FU, 4'd3, $urandom);
    drive((r + 2) % NUM_FU, 4'd4, $urandom);
    cycle();
    idle();
    squash_valid = 1'b1;
    drive((r + 3) % NUM_FU, 4'd14, $urandom);
    cycle();
    idle();
    checks++;
    if (cdb_valid !== 1'b0 || cdb_rob_tag !== '0 || cdb_v !== '0 || fifo_occupancy !== '0) begin
      errors++;
      $display("FAIL squash_kill: got valid=%b tag=%0d v=%h occ=%b want 0/0/0/0",
               cdb_valid, cdb_rob_tag, cdb_v, fifo_occupancy);
    end
    drive(1, 4'd10, 32'h0000_00AA);
    cycle();
    idle();
    checks++;
    if (cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL squash_no_leftover: got valid=%b tag=%0d want 0", cdb_valid, cdb_rob_tag);
    end
    cycle();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_rob_tag !== 4'd10 || cdb_v !== 32'h0000_00AA) begin
      errors++;
      $display("FAIL squash_recover: got valid=%b tag=%0d v=%h want 1/10/000000aa",
               cdb_valid, cdb_rob_tag, cdb_v);
    end
    cycle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      idle();
      squash_valid = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < NUM_FU; i++)
        if ($urandom_range(0, 1) == 1) drive(i, TAG_W'($urandom_range(0, 15)), $urandom);
      checks++;
      if (fu_ready !== exp_ready()) begin
        errors++;
        $display("FAIL rand_ready c%0d: got %b want %b", c, fu_ready, exp_ready());
      end
      cycle();
      checks++;
      if ({cdb_valid, cdb_rob_tag, cdb_v, fifo_occupancy} !==
          {exp_valid, exp_tag, exp_v, exp_occ()}) begin
        errors++;
        $display("FAIL rand_out c%0d: got v=%b t=%0d d=%h o=%b want v=%b t=%0d d=%h o=%b",
                 c, cdb_valid, cdb_rob_tag, cdb_v, fifo_occupancy,
                 exp_valid, exp_tag, exp_v, exp_occ());
      end
    end
    idle();
  endtask

  task automatic test_tag0_reset();
    idle();
    repeat (5) cycle();
    checks++;
    if (fu_ready !== 4'b1111) begin
      errors++;
      $display("FAIL tag0_pre_ready: got %b want 1111", fu_ready);
    end
    drive(3, 4'd0, 32'h1234_5678);
    cycle();
    idle();
    checks++;
    if (fifo_occupancy !== '0 || fu_ready !== 4'b1111) begin
      errors++;
      $display("FAIL tag0_dropped: got occ=%b ready=%b want 0/1111", fifo_occupancy, fu_ready);
    end
    cycle();
    checks++;
    if (cdb_valid !== 1'b0 || cdb_rob_tag !== '0) begin
      errors++;
      $display("FAIL tag0_no_bcast: got valid=%b tag=%0d want 0/0", cdb_valid, cdb_rob_tag);
    end
    drive(0, 4'd1, $urandom);
    drive(1, 4'd2, $urandom);
    drive(2, 4'd3, $urandom);
    cycle();
    idle();
    cycle();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_rob_tag !== exp_tag || fifo_occupancy !== exp_occ()) begin
      errors++;
      $display("FAIL rst_preload: got valid=%b tag=%0d occ=%b want 1/%0d/%b",
               cdb_valid, cdb_rob_tag, fifo_occupancy, exp_tag, exp_occ());
    end
    #2 reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({cdb_valid, cdb_rob_tag, cdb_v, fifo_occupancy} !== '0 || fu_ready !== '0) begin
      errors++;
      $display("FAIL rst_async: got valid=%b tag=%0d v=%h occ=%b ready=%b want all 0",
               cdb_valid, cdb_rob_tag, cdb_v, fifo_occupancy, fu_ready);
    end
    @(posedge clock);
    #1;
    checks++;
    if (fu_ready !== '0 || cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_held: got ready=%b valid=%b want 0/0", fu_ready, cdb_valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (fu_ready !== 4'b1111) begin
      errors++;
      $display("FAIL rst_release_ready: got %b want 1111", fu_ready);
    end
    cycle();
    checks++;
    if (cdb_valid !== 1'b0 || fifo_occupancy !== '0) begin
      errors++;
      $display("FAIL rst_nothing_left: got valid=%b occ=%b want 0/0", cdb_valid, fifo_occupancy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_squash();
    test_random();
    test_tag0_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
